pe_drain: RTL and testbench

PE_DRAIN -- requirements
Module: pe_drain

---
 rtl/pe_drain.sv | 166 ++++++++++++++++
 tb/tb_pe_drain.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_drain.sv
// Drains one PE result stream: waits COMPUTE_CYCLES after i_start, captures N words
// into a small FIFO, then flushes it downstream. Optional order check: define PE_DRAIN_ORDER_CHECK_EN.
module pe_drain #(
  parameter int N              = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int COMPUTE_CYCLES = 7,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_PE,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic                  o_order_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (COMPUTE_CYCLES > 2) ? $clog2(COMPUTE_CYCLES) : 1;

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CAP  = CW'(N-1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(COMPUTE_CYCLES-1);
  localparam bit            SKIP_WAIT = (COMPUTE_CYCLES < 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [WW-1:0]           wait_cnt_q;
  logic [CW-1:0]           cap_cnt_q;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q, count_d;
  logic                    valid_q;
  logic                    overflow_q;

  logic                    start_acc;
  logic                    capture;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    drop;

  assign start_acc  = (state_q == IDLE) && i_start;
  assign capture    = (state_q == CAPTURE);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = valid_q && i_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push       = capture && (!fifo_full || pop);
  assign drop       = capture && fifo_full && !pop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first, otherwise unlisted paths would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = SKIP_WAIT ? CAPTURE : WAIT;
      // Leave on the edge where the counter reaches 0, so capture starts COMPUTE_CYCLES after start.
      WAIT:    if (wait_cnt_q <= WW'(1)) state_d = CAPTURE;
      CAPTURE: if (cap_cnt_q == LAST_CAP) state_d = FLUSH;
      FLUSH:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_done = 1'b0;
    if (state_q == FLUSH && fifo_empty) o_done = 1'b1;
  end

  // ----------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      cap_cnt_q  <= '0;
    end else if (start_acc) begin
      wait_cnt_q <= WAIT_LOAD;
      cap_cnt_q  <= '0;
    end else begin
      if (state_q == WAIT && wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - WW'(1);
      if (capture) cap_cnt_q <= (cap_cnt_q == LAST_CAP) ? '0 : cap_cnt_q + CW'(1);
    end
  end

  // --------------------------------------------------------------- FIFO
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by pointers/count and o_data is masked when invalid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_PE;
  end

  assign o_valid = valid_q;
  assign o_data  = valid_q ? mem[rd_ptr_q] : '0;

  // -------------------------------------------------------------- flags
  always_ff @(posedge clk) begin
    if (!rst)           overflow_q <= 1'b0;
    else if (start_acc) overflow_q <= 1'b0;
    else if (drop)      overflow_q <= 1'b1;
  end

  assign o_overflow = overflow_q;

`ifdef PE_DRAIN_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  order_err_q;

  // Every captured word is compared, including ones the full FIFO drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else if (start_acc) begin
      order_err_q <= 1'b0;
    end else if (capture) begin
      prev_q <= i_PE;
      if (cap_cnt_q != '0 && i_PE < prev_q) order_err_q <= 1'b1;
    end
  end

  assign o_order_err = order_err_q;
`else
  assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_drain.sv
// Scoreboard bench for pe_drain: two instances (FIFO_DEPTH 4 and 2) share the stimulus;
// directed runs with hand-computed expected words, cycle-accurate flag/valid/done checks.
module tb_pe_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic       i_ready = 1'b1;
  logic [7:0] i_PE = 8'h00;

  logic [7:0] data4, data2;
  logic       valid4, valid2, done4, done2, ovf4, ovf2, oerr4, oerr2;

  int n_cmp = 0;
  int n_bad = 0;
  int t_now = -1;

  logic [7:0] q4[$];
  logic [7:0] q2[$];

  pe_drain #(.N(4), .DATA_WIDTH(8), .COMPUTE_CYCLES(7), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_PE(i_PE),
    .o_data(data4), .o_valid(valid4), .i_ready(i_ready), .o_done(done4),
    .o_overflow(ovf4), .o_order_err(oerr4)
  );

  pe_drain #(.N(4), .DATA_WIDTH(8), .COMPUTE_CYCLES(7), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_PE(i_PE),
    .o_data(data2), .o_valid(valid2), .i_ready(i_ready), .o_done(done2),
    .o_overflow(ovf2), .o_order_err(oerr2)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b (cycle %0d)", name, act, exp, t_now);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, t_now);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, t_now);
    end
  endtask

  // Push the first n4 / n2 bytes (MSB first) of words into the two scoreboard queues.
  task automatic expect_words(input logic [31:0] words, input int n4, input int n2);
    for (int i = 0; i < n4; i++) q4.push_back(words[8*(3-i) +: 8]);
    for (int i = 0; i < n2; i++) q2.push_back(words[8*(3-i) +: 8]);
  endtask

  function automatic logic [7:0] pe_at(input int t, input int base, input logic [31:0] words);
    if (t >= base && t < base + 4) return words[8*(3-(t-base)) +: 8];
    return 8'hEE;
  endfunction

  function automatic logic exp_order(input int t, input int from);
`ifdef PE_DRAIN_ORDER_CHECK_EN
    return (t >= from);
`else
    return 1'b0;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted word is compared with the front of its queue.
  always @(negedge clk) begin
    if (rst && valid4 && i_ready) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb4_extra: got 0x%0h, want no word (cycle %0d)", data4, t_now);
      end else check8("sb4_data", data4, q4.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst && valid2 && i_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb2_extra: got 0x%0h, want no word (cycle %0d)", data2, t_now);
      end else check8("sb2_data", data2, q2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    check1("rst_valid4", valid4, 1'b0);
    check1("rst_done4", done4, 1'b0);
    check1("rst_ovf4", ovf4, 1'b0);
    check1("rst_oerr4", oerr4, 1'b0);
    check8("rst_data4", data4, 8'h00);
    check1("rst_valid2", valid2, 1'b0);
    check8("rst_data2", data2, 8'h00);
    next_cycle();
    rst = 1'b1;
    repeat (3) next_cycle();

    // Basic run: 3,5,9,12 with the consumer always ready
    w = {8'd3, 8'd5, 8'd9, 8'd12};
    expect_words(w, 4, 4);
    for (int t = 0; t <= 15; t++) begin
      t_now = t;
      i_ready = 1'b1;
      i_start = (t == 0);
      i_PE = pe_at(t, 7, w);
      @(negedge clk);
      check1("A_valid4", valid4, t >= 8 && t <= 11);
      check1("A_valid2", valid2, t >= 8 && t <= 11);
      check1("A_done4", done4, t == 12);
      check1("A_done2", done2, t == 12);
      check1("A_ovf4", ovf4, 1'b0);
      check1("A_oerr4", oerr4, 1'b0);
      next_cycle();
    end
    checki("A_q4_left", q4.size(), 0);
    checki("A_q2_left", q2.size(), 0);

    // Backpressure (depth 4) / overflow (depth 2): ready low through capture of 1,2,3,4
    w = {8'd1, 8'd2, 8'd3, 8'd4};
    expect_words(w, 4, 2);
    for (int t = 0; t <= 19; t++) begin
      t_now = t;
      i_ready = (t >= 13);
      i_start = (t == 0);
      i_PE = pe_at(t, 7, w);
      @(negedge clk);
      check1("B_valid4", valid4, t >= 8 && t <= 16);
      check1("B_valid2", valid2, t >= 8 && t <= 14);
      check1("B_done4", done4, t == 17);
      check1("B_done2", done2, t == 15);
      check1("B_ovf4", ovf4, 1'b0);
      check1("B_ovf2", ovf2, t >= 10);
      if (t >= 8 && t <= 13) begin
        check8("B_hold4", data4, 8'd1);
        check8("B_hold2", data2, 8'd1);
      end
      next_cycle();
    end
    checki("B_q4_left", q4.size(), 0);
    checki("B_q2_left", q2.size(), 0);

    // Order check: 4,2,7,8; also overflow flag from the previous run is cleared by start
    w = {8'd4, 8'd2, 8'd7, 8'd8};
    expect_words(w, 4, 4);
    for (int t = 0; t <= 14; t++) begin
      t_now = t;
      i_ready = 1'b1;
      i_start = (t == 0);
      i_PE = pe_at(t, 7, w);
      @(negedge clk);
      if (t >= 1) begin
        check1("C_ovf2_clr", ovf2, 1'b0);
        check1("C_oerr4", oerr4, exp_order(t, 9));
        check1("C_oerr2", oerr2, exp_order(t, 9));
      end
      check1("C_valid4", valid4, t >= 8 && t <= 11);
      check1("C_done4", done4, t == 12);
      next_cycle();
    end
    checki("C_q4_left", q4.size(), 0);

    // Reset mid-capture at cycle 9, then a clean run started at cycle 12
    q4.push_back(8'd10);
    q2.push_back(8'd10);
    expect_words({8'd50, 8'd60, 8'd70, 8'd80}, 4, 4);
    for (int t = 0; t <= 26; t++) begin
      t_now = t;
      i_ready = 1'b1;
      rst = (t != 9);
      i_start = (t == 0) || (t == 12);
      if (t < 12) i_PE = pe_at(t, 7, {8'd10, 8'd20, 8'd30, 8'd40});
      else        i_PE = pe_at(t, 19, {8'd50, 8'd60, 8'd70, 8'd80});
      @(negedge clk);
      if (t >= 1 && t != 9) begin
        check1("D_valid4", valid4, t == 8 || (t >= 20 && t <= 23));
        check1("D_valid2", valid2, t == 8 || (t >= 20 && t <= 23));
      end
      check1("D_done4", done4, t == 24);
      check1("D_done2", done2, t == 24);
      if (t >= 1) check1("D_oerr4", oerr4, 1'b0);
      if (t == 10) check8("D_data4_rst", data4, 8'h00);
      next_cycle();
    end
    rst = 1'b1;
    checki("D_q4_left", q4.size(), 0);
    checki("D_q2_left", q2.size(), 0);

    // i_start during WAIT at cycle 3 is ignored
    w = {8'h11, 8'h22, 8'h33, 8'h44};
    expect_words(w, 4, 4);
    for (int t = 0; t <= 15; t++) begin
      t_now = t;
      i_ready = 1'b1;
      i_start = (t == 0) || (t == 3);
      i_PE = pe_at(t, 7, w);
      @(negedge clk);
      check1("E_valid4", valid4, t >= 8 && t <= 11);
      check1("E_done4", done4, t == 12);
      check1("E_done2", done2, t == 12);
      next_cycle();
    end
    i_start = 1'b0;
    checki("E_q4_left", q4.size(), 0);
    checki("E_q2_left", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
